// File: rtl/branch_pkg.sv
// branch_pkg: condition codes, flag indices, BHT reset value and condition evaluation shared by the branch resolve slice
package branch_pkg;

    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    localparam logic [1:0] BHT_RST = 2'b01;

    // Decide a branch condition against a {Z,V,N} flag vector
    function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] f);
        logic z, v, n;
        z = f[FLAG_Z];
        v = f[FLAG_V];
        n = f[FLAG_N];
        case (ccc)
            CC_NE:   cond_met = ~z;
            CC_EQ:   cond_met = z;
            CC_GT:   cond_met = ~z & ~n;
            CC_LT:   cond_met = n;
            CC_GE:   cond_met = z | ~n;
            CC_LE:   cond_met = z | n;
            CC_OV:   cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: flag, branch, resolution and fetch-prediction signals of the branch resolve unit
interface branch_resolve_unit_if #(
    parameter int PC_W   = 16,
    parameter int OFFS_W = 9
);
    logic [2:0]        flag_we;
    logic [2:0]        flag_in;
    logic [2:0]        flags_out;
    logic              br_valid;
    logic [2:0]        br_ccc;
    logic              br_reg;
    logic [PC_W-1:0]   br_pc;
    logic [OFFS_W-1:0] br_offset;
    logic [PC_W-1:0]   br_reg_target;
    logic              br_pred;
    logic              flush;
    logic              res_valid;
    logic              res_taken;
    logic [PC_W-1:0]   res_target;
    logic              res_mispredict;
    logic [PC_W-1:0]   fetch_pc;
    logic              fetch_pred_taken;

    modport master (
        output flag_we, flag_in, br_valid, br_ccc, br_reg, br_pc, br_offset,
               br_reg_target, br_pred, flush, fetch_pc,
        input  flags_out, res_valid, res_taken, res_target, res_mispredict,
               fetch_pred_taken
    );

    modport slave (
        input  flag_we, flag_in, br_valid, br_ccc, br_reg, br_pc, br_offset,
               br_reg_target, br_pred, flush, fetch_pc,
        output flags_out, res_valid, res_taken, res_target, res_mispredict,
               fetch_pred_taken
    );

endinterface

// File: rtl/branch_bht.sv
// branch_bht: 2-bit saturating counter table, combinational read (pre-update) and one update port
module branch_bht
    import branch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PC_W  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] rd_pc,
    output logic            rd_taken,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken
);
    localparam int IW = $clog2(DEPTH);

    logic [1:0]    cnt [DEPTH];
    logic [IW-1:0] ri, ui;
    logic [1:0]    cur, nxt;

    assign ri       = rd_pc[IW:1];
    assign ui       = upd_pc[IW:1];
    assign rd_taken = cnt[ri][1];
    assign cur      = cnt[ui];

    // Saturating step of the addressed counter
    always_comb begin
        nxt = upd_taken ? ((cur == 2'b11) ? cur : cur + 2'b01)
                        : ((cur == 2'b00) ? cur : cur - 2'b01);
    end

    // Counter storage; reset returns every entry to weakly not-taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) cnt[i] <= BHT_RST;
        end else if (upd_en) begin
            cnt[ui] <= nxt;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: flag register, one-stage branch resolution and target calculation; BRANCH_PREDICT_EN adds the BHT
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int OFFS_W    = 9,
    parameter int BHT_DEPTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_resolve_unit_if.slave bus
);
    logic [2:0]      flags;
    logic            fire, taken;
    logic [PC_W-1:0] seq, off_ext, target;

    assign fire          = bus.br_valid & ~bus.flush;
    assign bus.flags_out = flags;

    // Evaluate against the registered flags so same-cycle flag writes stay invisible
    always_comb begin
        taken   = cond_met(bus.br_ccc, flags);
        seq     = bus.br_pc + PC_W'(2);
        off_ext = {{(PC_W-OFFS_W){bus.br_offset[OFFS_W-1]}}, bus.br_offset};
        target  = !taken ? seq : bus.br_reg ? bus.br_reg_target : seq + (off_ext << 1);
    end

    // Flag bits update individually under their own write enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags <= 3'b000;
        else        flags <= (flags & ~bus.flag_we) | (bus.flag_in & bus.flag_we);
    end

    // Resolution stage: valid pulses for one cycle, payload holds until the next branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res_valid      <= 1'b0;
            bus.res_taken      <= 1'b0;
            bus.res_target     <= '0;
            bus.res_mispredict <= 1'b0;
        end else begin
            bus.res_valid <= fire;
            if (fire) begin
                bus.res_taken      <= taken;
                bus.res_target     <= target;
                bus.res_mispredict <= taken ^ bus.br_pred;
            end
        end
    end

`ifdef BRANCH_PREDICT_EN
    branch_bht #(
        .DEPTH (BHT_DEPTH),
        .PC_W  (PC_W)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_pc     (bus.fetch_pc),
        .rd_taken  (bus.fetch_pred_taken),
        .upd_en    (fire),
        .upd_pc    (bus.br_pc),
        .upd_taken (taken)
    );
`else
    assign bus.fetch_pred_taken = 1'b0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the processor's combinational condition-code branch decision.
- Adds a registered Z/V/N flag register with per-flag write enables.
- Resolves branches in one registered stage and computes the branch target with a configurable PC width.
- Optionally includes a 2-bit-counter branch history table (BHT) that supplies fetch-time predictions and flags mispredicts back to the pipeline.

Parameters:
- PC_W, 16, width of PC and target addresses.
- OFFS_W, 9, width of the signed immediate branch offset, in halfwords.
- BHT_DEPTH, 16, number of BHT entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flag_we  in  3  per-flag write enable, bit order {Z,V,N}.
- flag_in  in  3  new flag values from the ALU, {Z,V,N}.
- flags_out  out  3  current registered flags, {Z,V,N}.
- br_valid  in  1  a branch is presented this cycle.
- br_ccc  in  3  condition code.
- br_reg  in  1  1 = register-target branch, 0 = PC-relative.
- br_pc  in  PC_W  address of the branch instruction.
- br_offset  in  OFFS_W  signed halfword offset.
- br_reg_target  in  PC_W  register target.
- br_pred  in  1  prediction the pipeline attached to this branch.
- flush  in  1  kill the branch presented this cycle.
- res_valid  out  1  resolution result valid (one-cycle pulse).
- res_taken  out  1  resolved direction.
- res_target  out  PC_W  next PC for the resolved branch.
- res_mispredict  out  1  res_taken differs from the carried br_pred.
- fetch_pc  in  PC_W  fetch address for prediction lookup.
- fetch_pred_taken  out  1  predicted direction for fetch_pc (combinational).

Behaviour:
- Reset (asynchronous, rst_n low):
  - flags = 3'b000; res_valid, res_taken, res_mispredict = 0; res_target = 0.
  - All BHT counters = 2'b01.
  - Takes effect immediately, including mid-resolution; a branch presented in the reset cycle is lost.
- Flag register:
  - Each bit is written from flag_in only when its flag_we bit is 1; otherwise it holds.
- Condition evaluation:
  - Uses the registered flags only. Flags written in the same cycle as br_valid are not visible to that branch (old flags are used).
  - Encoding:
    - 000 NE: ~Z
    - 001 EQ: Z
    - 010 GT: ~Z & ~N
    - 011 LT: N
    - 100 GE: Z | ~N
    - 101 LE: Z | N
    - 110 OV: V
    - 111 unconditional: 1
- Resolution latency:
  - br_valid & ~flush at edge N gives res_valid = 1 during cycle N+1 only, with res_taken, res_target and res_mispredict registered at the same edge.
  - Back-to-back branches on consecutive cycles are fully supported.
  - res_taken, res_target and res_mispredict hold their values when res_valid = 0.
- Target computation:
  - seq = br_pc + 2.
  - Taken and br_reg = 1: target = br_reg_target.
  - Taken and br_reg = 0: target = seq + (sign_extend(br_offset) << 1).
  - Not taken: target = seq.
  - All arithmetic is modulo 2^PC_W; wrap-around is silent.
- res_mispredict = taken XOR br_pred.
- flush = 1 with br_valid = 1: no res_valid pulse next cycle and no BHT update. The flag register is unaffected by flush.
- BHT:
  - Index = pc[log2(BHT_DEPTH):1].
  - fetch_pred_taken = counter[fetch index][1].
  - At each resolution edge, the counter at the br_pc index is incremented if taken, decremented otherwise, saturating at 0 and 3. Unconditional branches also update.
  - A lookup and an update to the same index in the same cycle: the lookup returns the pre-update value (read-before-write).

Optional Feature:
- Macro: BRANCH_PREDICT_EN.
- Defined: the BHT exists as described above.
- Undefined: no BHT storage; fetch_pred_taken is constant 0; res_mispredict still computed as taken XOR br_pred.

Decomposition:
- Shared package branch_pkg:
  - Condition-code constants CC_NE, CC_EQ, CC_GT, CC_LT, CC_GE, CC_LE, CC_OV, CC_UNC.
  - Flag bit indices FLAG_Z = 2, FLAG_V = 1, FLAG_N = 0.
  - BHT counter reset constant 2'b01.
- One sub-module, branch_bht: counter array with combinational read port and saturating update port; instantiated only under BRANCH_PREDICT_EN.

Test Plan:
- Reset, then flag_we = 3'b111, flag_in = 3'b100 (Z = 1). Next cycle br_ccc = 001, br_pc = 16'h0010, br_offset = 9'h004, br_pred = 0 -> next cycle res_valid = 1, res_taken = 1, res_target = 16'h001A, res_mispredict = 1.
- Flags {Z,V,N} = 000 with br_ccc = 010 and br_ccc = 011 on consecutive cycles -> GT taken then LT not taken (res_target = br_pc + 2); res_valid high two consecutive cycles.
- flag_we = 3'b001, flag_in = 3'b001 in the same cycle as br_ccc = 011 -> not taken (old N = 0); the following branch with br_ccc = 011 -> taken.
- br_pc = 16'hFFFE, br_offset = 9'h1FF (-1), br_ccc = 111 -> res_target = 16'hFFFE; br_reg = 1 with br_reg_target = 16'h1234 -> 16'h1234.
- br_valid = 1 with flush = 1 -> res_valid stays 0 and the BHT entry is unchanged.
- BRANCH_PREDICT_EN: three taken resolutions at br_pc = 16'h0004 -> fetch_pc = 16'h0004 reports 1 after the first; the counter saturates at 3; two not-taken resolutions -> prediction returns to 0; a same-cycle lookup during an update returns the pre-update value.
